// File: rtl/uop_sequencer.sv
// uop_sequencer: microcode engine for the curve point-operation blocks.
// Fetches 20-bit uops from a synchronous ROM, evaluates each uop's exec
// condition, issues it to the modular arithmetic datapath with a start/done
// handshake and stops on OPCODE_RDY (or with err when running off the ROM end).
//
// Uop format: [19:16] opcode, [15:11] src A, [10:6] src B, [5:2] dst, [1:0] exec.
module uop_sequencer #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  output logic              rdy,
  output logic              err,
  output logic [ADDR_W-1:0] uop_addr,
  input  logic [19:0]       uop_data,
  input  logic              cond,
  output logic              op_start,
  output logic [3:0]        op_opcode,
  output logic [4:0]        op_src_a,
  output logic [4:0]        op_src_b,
  output logic [3:0]        op_dst,
  input  logic              op_done
);

  localparam logic [3:0]        OPCODE_RDY = 4'h0;
  localparam logic [ADDR_W-1:0] START_A    = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ADDR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_BUSY   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // Exec field: 00 always, 01 if cond, 10 if !cond, 11 never.
  function automatic logic exec_ok(input logic [1:0] exec, input logic c);
    logic ok;
    case (exec)
      2'b00:   ok = 1'b1;
      2'b01:   ok = c;
      2'b10:   ok = ~c;
      2'b11:   ok = 1'b0;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rdy_q, rdy_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [3:0]        opc_q, opc_d;
  logic [4:0]        src_a_q, src_a_d;
  logic [4:0]        src_b_q, src_b_d;
  logic [3:0]        dst_q, dst_d;
  logic              ena_dly_q;

  logic              start_s;
  state_e            adv_state_s;
  logic [ADDR_W-1:0] adv_addr_s;
  logic              adv_err_s;

  // Only a rising edge of ena requests a run; a held level never restarts.
  assign start_s = ena & ~ena_dly_q;

  // Advance to the next uop, or flag err when the current one is the last address.
  always_comb begin
    if (addr_q == LAST_ADDR) begin
      adv_state_s = S_DONE;
      adv_addr_s  = addr_q;
      adv_err_s   = 1'b1;
    end else begin
      adv_state_s = S_FETCH;
      adv_addr_s  = addr_q + ADDR_ONE;
      adv_err_s   = 1'b0;
    end
  end

  // Next-state and registered-output logic of the sequencing FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rdy_d   = rdy_q;
    err_d   = err_q;
    start_d = 1'b0;
    opc_d   = opc_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    dst_d   = dst_q;
    case (state_q)
      S_IDLE: begin
        if (start_s) begin
          addr_d  = START_A;
          rdy_d   = 1'b0;
          err_d   = 1'b0;
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // ROM data for addr_q becomes valid at the end of this cycle.
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (uop_data[19:16] == OPCODE_RDY) begin
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end else if (exec_ok(uop_data[1:0], cond)) begin
          opc_d   = uop_data[19:16];
          src_a_d = uop_data[15:11];
          src_b_d = uop_data[10:6];
          dst_d   = uop_data[5:2];
          start_d = 1'b1;
          state_d = S_BUSY;
        end else begin
          state_d = adv_state_s;
          addr_d  = adv_addr_s;
          err_d   = adv_err_s;
          rdy_d   = adv_err_s;
        end
      end
      S_BUSY: begin
        // op_done counts even in the cycle op_start is high (zero-wait datapath).
        if (op_done) begin
          state_d = adv_state_s;
          addr_d  = adv_addr_s;
          err_d   = adv_err_s;
          rdy_d   = adv_err_s;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        rdy_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any program and leaves the engine idle with rdy high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      rdy_q     <= 1'b1;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      opc_q     <= 4'h0;
      src_a_q   <= 5'h00;
      src_b_q   <= 5'h00;
      dst_q     <= 4'h0;
      ena_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      start_q   <= start_d;
      opc_q     <= opc_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      ena_dly_q <= ena;
    end
  end

  assign rdy       = rdy_q;
  assign err       = err_q;
  assign uop_addr  = addr_q;
  assign op_start  = start_q;
  assign op_opcode = opc_q;
  assign op_src_a  = src_a_q;
  assign op_src_b  = src_b_q;
  assign op_dst    = dst_q;

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
- Microcode engine for the curve point-operation blocks.
- Fetches 20-bit micro-operations from a synchronous uop ROM (init, doubling, addition programs) and decodes each one.
- Evaluates each uop's execution condition and issues it to the modular arithmetic datapath with a start/done handshake.
- Stops on OPCODE_RDY and reports completion to the curve-level controller.

Parameters:
- ADDR_W, 6, uop ROM address width.
- START_ADDR, 0, first uop address fetched after a start request.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  start request; rising edge only.
- rdy  output  1  program finished or idle; sticky until next start.
- err  output  1  program ran past last address without OPCODE_RDY.
- uop_addr  output  ADDR_W  ROM address.
- uop_data  input  20  ROM data, valid one cycle after uop_addr.
- cond  input  1  condition flag from datapath.
- op_start  output  1  one-cycle issue strobe.
- op_opcode  output  4  uop_data[19:16].
- op_src_a  output  5  uop_data[15:11].
- op_src_b  output  5  uop_data[10:6].
- op_dst  output  4  uop_data[5:2].
- op_done  input  1  datapath completion pulse.

Behaviour:
- Uop format: [19:16] opcode, [15:11] src A, [10:6] src B, [5:2] dst, [1:0] exec.
- OPCODE_RDY = 4'h0. All other fields are ignored when the opcode is RDY.
- Exec field codes:
  - 00 = ALWAYS.
  - 01 = execute only if cond = 1.
  - 10 = execute only if cond = 0.
  - 11 = NEVER (skip).
- Reset (async): rdy=1, err=0, op_start=0, uop_addr=0, op_* fields=0, state IDLE. Assertion mid-program aborts immediately; no op_start is issued after reset.
- ena edge detect: ena_dly register; start = ena & ~ena_dly. Level-held ena does not restart.
- FSM states and transitions:
  - IDLE: on start → uop_addr<=START_ADDR, rdy<=0, err<=0, go to FETCH. Start while not IDLE is ignored.
  - FETCH: one wait cycle for ROM latency → DECODE.
  - DECODE: sample uop_data and cond.
    - opcode==RDY → DONE.
    - Condition false or exec==11 → skip path (see below).
    - Otherwise: register op_* fields, op_start<=1, go to BUSY.
  - BUSY: op_start<=0 after its first cycle. op_done is sampled only in this state, including the cycle op_start is high (a zero-wait datapath is legal). On op_done → advance path.
  - Skip/advance path: if uop_addr == 2^ADDR_W-1 → err<=1, go to DONE. Else uop_addr<=uop_addr+1, go to FETCH. No wrap-around.
  - DONE: rdy<=1, go to IDLE.
- Timing and output stability:
  - Minimum cost is 3 cycles per executed uop and 2 cycles per skipped uop.
  - op_* fields hold their value from issue until the next issue.
  - op_done outside BUSY is ignored.
- err stays high until the next start. err implies rdy.

Test Plan:
- Init program, op_done tied high: ena pulse at cycle 0 → three op_start pulses with (op_dst RX, src A ONE), (RY, ONE), (RZ, ZERO) in order at cycles 3, 6, 9. rdy rises at cycle 12; err=0.
- Program [MOV exec=01, MOV exec=10, RDY] with cond=0 → exactly one op_start, carrying the second uop's fields. uop_addr sequence 0,1,2.
- op_done delayed 20 cycles on every uop, plus a spurious op_done pulse during FETCH → no extra issue. Each uop_addr advance happens only after the real done.
- ROM filled with 64 non-RDY ALWAYS uops → 64 issues; after the last uop, err=1, rdy=1, uop_addr=63.
- rst_n pulled low in BUSY of the second uop → all outputs return to reset values asynchronously. After release with no new ena edge: no op_start, rdy stays 1.
- ena held high across the DONE state → no second run. Dropping ena and raising it again → new run from START_ADDR.
